// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array edge feeders and MACs.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, SKEW, STREAM, FLUSH} feeder_state_e;

  localparam int WIDTH_P = 32;
  localparam int DEPTH_P = 8;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  typedef logic [cnt_width(DEPTH_P)-1:0] len_t;

endpackage

// File: rtl/systolic_feeder.sv
// Edge operand feeder: loads a K-element vector, waits skew_p cycles, streams one element per
// accepted beat with registered valid (no ready->valid path), then pulses flush for one cycle.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int width_p = WIDTH_P,
  parameter int depth_p = DEPTH_P,
  parameter int skew_p  = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             vec_valid_i,
  output logic                             vec_ready_o,
  input  logic [depth_p*width_p-1:0]       vec_i,
  input  logic [cnt_width(depth_p)-1:0]    len_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [width_p-1:0]               data_o,
  output logic                             flush_o,
  output logic                             busy_o
);

  localparam int LW = cnt_width(depth_p);
  localparam int SW = cnt_width(skew_p);

  feeder_state_e        state_q;
  logic [width_p-1:0]   elem_q [depth_p];
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        idx_q;
  logic [SW-1:0]        skew_q;
  logic [width_p-1:0]   data_q;
  logic                 valid_q;
  logic                 flush_q;
  logic                 vec_ready_q;
  logic                 busy_q;

  logic [LW-1:0]        len_d;
  logic [LW-1:0]        idx_d;
  logic [width_p-1:0]   elem_nxt;

  always_comb begin
    len_d    = (len_i > LW'(depth_p)) ? LW'(depth_p) : len_i;
    idx_d    = idx_q + LW'(1);
    elem_nxt = '0;
    for (int i = 0; i < depth_p; i++) begin
      if (idx_d == LW'(i)) elem_nxt = elem_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      skew_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vec_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (vec_valid_i && vec_ready_q) begin
            for (int i = 0; i < depth_p; i++) elem_q[i] <= vec_i[i*width_p +: width_p];
            len_q       <= len_d;
            idx_q       <= '0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            // An empty vector still closes the dot product, but skips skew entirely.
            if (len_d == '0) begin
              state_q <= FLUSH;
              flush_q <= 1'b1;
            end else if (skew_p > 0) begin
              state_q <= SKEW;
              skew_q  <= '0;
            end else begin
              state_q <= STREAM;
              valid_q <= 1'b1;
              data_q  <= vec_i[width_p-1:0];
            end
          end
        end
        SKEW: begin
          if (skew_q == SW'(skew_p - 1)) begin
            state_q <= STREAM;
            skew_q  <= '0;
            valid_q <= 1'b1;
            data_q  <= elem_q[0];
          end else begin
            skew_q <= skew_q + SW'(1);
          end
        end
        STREAM: begin
          if (ready_i) begin
            idx_q <= idx_d;
            if (idx_q == len_q - LW'(1)) begin
              state_q <= FLUSH;
              valid_q <= 1'b0;
              flush_q <= 1'b1;
            end else begin
              data_q <= elem_nxt;
            end
          end
        end
        FLUSH: begin
          state_q     <= IDLE;
          flush_q     <= 1'b0;
          idx_q       <= '0;
          vec_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_ready_o = vec_ready_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign flush_o     = flush_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: two instances (skew 2 and skew 0) checked against a per-vector timeline model.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int SKEW [2] = '{2, 0};

  logic        clk;
  logic        rst       [2];
  logic        vec_valid [2];
  logic        vec_ready [2];
  logic [255:0] vec      [2];
  len_t        len       [2];
  logic        valid     [2];
  logic        rdy       [2];
  logic [31:0] data      [2];
  logic        flush     [2];
  logic        busy      [2];

  int errors = 0;
  int checks = 0;
  int rdy_pat[$];

  systolic_feeder #(.width_p(32), .depth_p(8), .skew_p(2)) u_dut0 (
    .clk_i(clk), .reset_i(rst[0]), .vec_valid_i(vec_valid[0]), .vec_ready_o(vec_ready[0]),
    .vec_i(vec[0]), .len_i(len[0]), .valid_o(valid[0]), .ready_i(rdy[0]),
    .data_o(data[0]), .flush_o(flush[0]), .busy_o(busy[0]));

  systolic_feeder #(.width_p(32), .depth_p(8), .skew_p(0)) u_dut1 (
    .clk_i(clk), .reset_i(rst[1]), .vec_valid_i(vec_valid[1]), .vec_ready_o(vec_ready[1]),
    .vec_i(vec[1]), .len_i(len[1]), .valid_o(valid[1]), .ready_i(rdy[1]),
    .data_o(data[1]), .flush_o(flush[1]), .busy_o(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Loads one vector into feeder d and checks the whole expected timeline.
  // Entered and left at a negedge; keep leaves vec_valid high for a back-to-back load.
  task automatic run_vec(input int d, input logic [31:0] ev [8], input int ln,
                         input bit rand_rdy, input bit keep);
    int guard = 0;
    int n, sk, idx, stalls;
    bit r;
    while (!vec_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!vec_ready[d]) begin
      chk($sformatf("d%0d load_wait", d), 32'(vec_ready[d]), 32'd1);
      return;
    end
    for (int i = 0; i < 8; i++) vec[d][i*32 +: 32] = ev[i];
    len[d]       = len_t'(ln);
    vec_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) vec_valid[d] = 1'b0;
    vec[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n  = (ln > 8) ? 8 : ln;
    sk = (n == 0) ? 0 : SKEW[d];
    for (int s = 0; s < sk; s++) begin
      chk($sformatf("d%0d skew_valid", d), 32'(valid[d]), 32'd0);
      chk($sformatf("d%0d skew_flush", d), 32'(flush[d]), 32'd0);
      chk($sformatf("d%0d skew_vrdy", d), 32'(vec_ready[d]), 32'd0);
      chk($sformatf("d%0d skew_busy", d), 32'(busy[d]), 32'd1);
      rdy[d] = 1'($urandom);
      @(negedge clk);
    end
    idx = 0;
    stalls = 0;
    while (idx < n) begin
      chk($sformatf("d%0d strm_valid", d), 32'(valid[d]), 32'd1);
      chk($sformatf("d%0d strm_data%0d", d, idx), data[d], ev[idx]);
      chk($sformatf("d%0d strm_flush", d), 32'(flush[d]), 32'd0);
      chk($sformatf("d%0d strm_vrdy", d), 32'(vec_ready[d]), 32'd0);
      if (rdy_pat.size() > 0) r = (rdy_pat.pop_front() != 0);
      else if (rand_rdy) r = ($urandom_range(0, 2) != 0) || (stalls > 6);
      else r = 1'b1;
      stalls = r ? 0 : stalls + 1;
      rdy[d] = r;
      @(negedge clk);
      if (r) idx++;
    end
    chk($sformatf("d%0d flush_pulse", d), 32'(flush[d]), 32'd1);
    chk($sformatf("d%0d flush_valid", d), 32'(valid[d]), 32'd0);
    chk($sformatf("d%0d flush_vrdy", d), 32'(vec_ready[d]), 32'd0);
    rdy[d] = 1'($urandom);
    @(negedge clk);
    chk($sformatf("d%0d post_flush", d), 32'(flush[d]), 32'd0);
    chk($sformatf("d%0d post_vrdy", d), 32'(vec_ready[d]), 32'd1);
    chk($sformatf("d%0d post_busy", d), 32'(busy[d]), 32'd0);
    chk($sformatf("d%0d post_valid", d), 32'(valid[d]), 32'd0);
  endtask

  logic [31:0] ev [8];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; vec_valid[d] = 1'b0; vec[d] = '0; len[d] = '0; rdy[d] = 1'b0;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d rst_valid", d), 32'(valid[d]), 32'd0);
        chk($sformatf("d%0d rst_flush", d), 32'(flush[d]), 32'd0);
        chk($sformatf("d%0d rst_vrdy", d), 32'(vec_ready[d]), 32'd0);
        chk($sformatf("d%0d rst_busy", d), 32'(busy[d]), 32'd0);
        chk($sformatf("d%0d rst_data", d), data[d], 32'd0);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("d0 rel_vrdy", 32'(vec_ready[0]), 32'd1);
    chk("d1 rel_vrdy", 32'(vec_ready[1]), 32'd1);

    // Basic stream through the skewed feeder
    ev = '{322, 1750, 7, 0, 0, 0, 0, 0};
    run_vec(0, ev, 3, 1'b0, 1'b0);

    // Backpressure on the unskewed feeder
    ev = '{322, 465, 9, 9, 9, 9, 9, 9};
    rdy_pat = '{0, 0, 1, 0, 1};
    run_vec(1, ev, 2, 1'b0, 1'b0);

    // Length edges: empty vector and clamp above depth
    for (int i = 0; i < 8; i++) ev[i] = $urandom;
    run_vec(0, ev, 0, 1'b1, 1'b0);
    run_vec(1, ev, 9, 1'b0, 1'b0);
    run_vec(0, ev, 15, 1'b1, 1'b0);

    // Mid-stream reset after two accepted elements
    ev = '{101, 202, 303, 404, 505, 0, 0, 0};
    for (int i = 0; i < 8; i++) vec[1][i*32 +: 32] = ev[i];
    len[1] = len_t'(5); vec_valid[1] = 1'b1; rdy[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_valid[1] = 1'b0;
    chk("d1 mid_e0", data[1], ev[0]);
    @(negedge clk);
    chk("d1 mid_e1", data[1], ev[1]);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("d1 mid_valid", 32'(valid[1]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("d1 mid_noflush", 32'(flush[1]), 32'd0);
      @(negedge clk);
    end
    ev = '{11, 22, 0, 0, 0, 0, 0, 0};
    run_vec(1, ev, 2, 1'b0, 1'b0);

    // Back-to-back loads with vec_valid held high
    ev = '{5, 6, 7, 0, 0, 0, 0, 0};
    run_vec(0, ev, 3, 1'b1, 1'b1);
    ev = '{8, 9, 0, 0, 0, 0, 0, 0};
    run_vec(0, ev, 2, 1'b0, 1'b0);

    // Randomized vectors on both feeders
    for (int t = 0; t < 40; t++) begin
      int d = t % 2;
      for (int i = 0; i < 8; i++) ev[i] = $urandom;
      run_vec(d, ev, int'($urandom_range(0, 15)), 1'b1, 1'($urandom));
    end
    vec_valid[0] = 1'b0; vec_valid[1] = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
